// File: rtl/counter_pkg.sv
// counter_pkg: shared types and width helper for the up/down counter
package counter_pkg;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    // Prescaler counter width: $clog2(PRESCALE), never narrower than 1 bit.
    function automatic int pre_w(int prescale);
        return prescale > 1 ? $clog2(prescale) : 1;
    endfunction
    localparam int PRE_W = pre_w(1);
endpackage

// File: rtl/counter_updown_if.sv
// counter_updown_if: control/status bundle for counter_updown
// master drives enable/clear/load/load_val/dir/wrap/step/min/max,
// slave drives count/at_max/at_min/rollover/cfg_err.
interface counter_updown_if
    import counter_pkg::*;
#(
    parameter int N = 8
);
    logic enable, clear, load, wrap;
    dir_t dir;
    logic [N-1:0] load_val, step, min, max, count;
    logic at_max, at_min, rollover, cfg_err;
    modport master (
        output enable, clear, load, load_val, dir, wrap, step, min, max,
        input  count, at_max, at_min, rollover, cfg_err
    );
    modport slave (
        input  enable, clear, load, load_val, dir, wrap, step, min, max,
        output count, at_max, at_min, rollover, cfg_err
    );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing one tick every PRESCALE enabled cycles
// clk, rst: clock and sync reset; enable: advances pre_cnt;
// restart: zeroes pre_cnt; tick: enable && pre_cnt == PRESCALE-1.
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tick
);
    localparam int W = pre_w(PRESCALE);
    logic [W-1:0] pre_cnt;
    assign tick = enable && (pre_cnt == W'(PRESCALE - 1));
    always_ff @(posedge clk) begin
        if (rst || restart || tick)
            pre_cnt <= '0;
        else if (enable)
            pre_cnt <= pre_cnt + 1'b1;
    end
endmodule

// File: rtl/counter_updown.sv
// counter_updown: windowed up/down counter with prescaler, wrap/saturate and rollover pulse
// clk, rst: clock and sync reset; bus: counter_updown_if slave
// (controls in, count/at_max/at_min/rollover/cfg_err out).
module counter_updown
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    counter_updown_if.slave     bus
);
    logic         tick, up_ok, dn_ok, do_step, wrapped, roll;
    logic [N-1:0] cnt, nxt;
    logic [N:0]   sum, lo;
    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .enable  (bus.enable),
        .restart (bus.clear | bus.load),
        .tick    (tick)
    );
    // One extra bit keeps count+step and min+step from overflowing.
    assign sum     = {1'b0, cnt} + {1'b0, bus.step};
    assign lo      = {1'b0, bus.min} + {1'b0, bus.step};
    assign up_ok   = sum <= {1'b0, bus.max};
    assign dn_ok   = {1'b0, cnt} >= lo;
    // step == 0 must hold even when count sits outside the window.
    assign do_step = tick && !bus.cfg_err && (bus.step != '0);
    always_comb begin
        wrapped = bus.wrap && (bus.dir == DIR_UP ? !up_ok : !dn_ok);
        nxt = bus.dir == DIR_UP
            ? (up_ok ? sum[N-1:0] : bus.wrap ? bus.min : bus.max)
            : (dn_ok ? cnt - bus.step : bus.wrap ? bus.max : bus.min);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            roll <= 1'b0;
        end else if (bus.clear) begin
            cnt  <= bus.min;
            roll <= 1'b0;
        end else if (bus.load) begin
            cnt  <= bus.load_val;
            roll <= 1'b0;
        end else begin
            roll <= do_step && wrapped;
            if (do_step)
                cnt <= nxt;
        end
    end
    assign bus.count    = cnt;
    assign bus.rollover = roll;
    assign bus.at_max   = cnt == bus.max;
    assign bus.at_min   = cnt == bus.min;
    assign bus.cfg_err  = bus.min > bus.max;
endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: directed plus random checks of counter_updown (PRESCALE 1 and 4) against an integer model
module tb_counter_updown;
    import counter_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic en = 0, clr = 0, ld = 0, dr = 0, wr = 1;
    logic [7:0] lv = 0, st = 1, mn = 0, mx = 9;
    int errors = 0, checks = 0;
    int m_cnt[2], m_pre[2];
    bit m_roll[2];
    int ps[2] = '{1, 4};

    counter_updown_if #(.N(8)) b1 ();
    counter_updown_if #(.N(8)) b4 ();
    assign b1.enable = en;  assign b4.enable = en;
    assign b1.clear = clr;  assign b4.clear = clr;
    assign b1.load = ld;    assign b4.load = ld;
    assign b1.load_val = lv; assign b4.load_val = lv;
    assign b1.dir = dir_t'(dr); assign b4.dir = dir_t'(dr);
    assign b1.wrap = wr;    assign b4.wrap = wr;
    assign b1.step = st;    assign b4.step = st;
    assign b1.min = mn;     assign b4.min = mn;
    assign b1.max = mx;     assign b4.max = mx;

    counter_updown #(.N(8), .PRESCALE(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    counter_updown #(.N(8), .PRESCALE(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic, advanced once per clock.
    function automatic void mstep(int k);
        int c = m_cnt[k];
        bit tick = en && (m_pre[k] == ps[k] - 1);
        m_roll[k] = 0;
        if (en) m_pre[k] = tick ? 0 : m_pre[k] + 1;
        if (rst || clr || ld) m_pre[k] = 0;
        if (rst) m_cnt[k] = 0;
        else if (clr) m_cnt[k] = mn;
        else if (ld) m_cnt[k] = lv;
        else if (tick && mn <= mx && st != 0) begin
            if (!dr) begin
                if (c + st <= mx) m_cnt[k] = c + st;
                else if (wr) begin m_cnt[k] = mn; m_roll[k] = 1; end
                else m_cnt[k] = mx;
            end else begin
                if (c >= mn + st) m_cnt[k] = c - st;
                else if (wr) begin m_cnt[k] = mx; m_roll[k] = 1; end
                else m_cnt[k] = mn;
            end
        end
    endfunction

    task automatic cyc();
        for (int k = 0; k < 2; k++) mstep(k);
        @(posedge clk);
        #1;
        chk("count_p1", b1.count, m_cnt[0]);
        chk("roll_p1", b1.rollover, m_roll[0]);
        chk("atmax_p1", b1.at_max, m_cnt[0] == mx);
        chk("atmin_p1", b1.at_min, m_cnt[0] == mn);
        chk("cfgerr_p1", b1.cfg_err, mn > mx);
        chk("count_p4", b4.count, m_cnt[1]);
        chk("roll_p4", b4.rollover, m_roll[1]);
        chk("atmax_p4", b4.at_max, m_cnt[1] == mx);
        chk("atmin_p4", b4.at_min, m_cnt[1] == mn);
    endtask

    initial begin
        m_cnt = '{0, 0}; m_pre = '{0, 0}; m_roll = '{0, 0};
        cyc(); cyc();
        rst = 0;
        // count 0..9 then wrap to 0
        en = 1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("wrap_seq", b1.count, i % 10);
            chk("wrap_seq_roll", b1.rollover, i == 10);
        end
        // saturate down from a load of 13
        mn = 5; mx = 20; dr = 1; wr = 0; st = 4; lv = 13; ld = 1;
        cyc(); ld = 0;
        chk("sat_load", b1.count, 13);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("sat_dn", b1.count, i == 0 ? 9 : 5);
        end
        repeat (6) cyc();
        // overflow guard then wrap down below min
        mn = 250; mx = 255; dr = 0; st = 3; wr = 0; lv = 254; ld = 1;
        cyc(); ld = 0;
        cyc();
        chk("sat_ovf", b1.count, 255);
        wr = 1; dr = 1; st = 10;
        cyc();
        chk("wrap_dn", b1.count, 255);
        chk("wrap_dn_roll", b1.rollover, 1);
        cyc();
        // prescaler: tick after the 4th enabled cycle
        rst = 1; cyc(); rst = 0;
        mn = 0; mx = 9; dr = 0; wr = 1; st = 1;
        for (int i = 0; i < 5; i++) begin
            en = (i != 2);
            cyc();
            chk("presc", b4.count, i == 4 ? 1 : 0);
        end
        en = 1;
        repeat (2) cyc();
        // clear beats load, then load alone; no step either cycle
        clr = 1; ld = 1; lv = 7;
        cyc();
        chk("prio_clr", b1.count, 0);
        clr = 0;
        cyc();
        chk("prio_ld", b1.count, 7);
        ld = 0;
        // bad window holds the count; reset mid-run
        mn = 10; mx = 3;
        repeat (4) cyc();
        chk("cfg_hold", b1.count, 7);
        rst = 1; cyc(); rst = 0;
        chk("mid_rst", b1.count, 0);
        mn = 0; mx = 9;
        repeat (5) cyc();
        // random phase
        for (int i = 0; i < 500; i++) begin
            en  = ($urandom % 4) != 0;
            rst = ($urandom % 64) == 0;
            clr = ($urandom % 32) == 0;
            ld  = ($urandom % 24) == 0;
            lv  = 8'($urandom);
            dr  = 1'($urandom);
            wr  = 1'($urandom);
            st  = 8'($urandom % 9);
            if ($urandom % 16 == 0) begin
                mn = 8'($urandom);
                mx = ($urandom % 3 == 0) ? 8'd255 : 8'($urandom);
                if (mn > mx && $urandom % 4 != 0) {mn, mx} = {mx, mn};
            end
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
